// File: rtl/kettle_controller.sv
// rtl/kettle_controller.sv - kettle control FSM with boil/keep-warm modes and latched protection faults
module kettle_controller #(
    parameter int TEMP_W       = 8,
    parameter int BOIL_TEMP    = 100,
    parameter int MAX_TEMP     = 120,
    parameter int HYST         = 4,
    parameter int HEAT_TIMEOUT = 1000,
    parameter int HOLD_CYCLES  = 5000,
    parameter int TIMER_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_button,
    input  logic              keep_warm,
    input  logic [TEMP_W-1:0] warm_setpoint,
    input  logic [TEMP_W-1:0] temperature_sensor,
    input  logic              water_level_sensor,
    output logic              heater,
    output logic              indicator,
    output logic              shutdown,
    output logic [1:0]        fault_code,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [TEMP_W-1:0]  BOIL_T    = TEMP_W'(BOIL_TEMP);
    localparam logic [TEMP_W-1:0]  MAX_T     = TEMP_W'(MAX_TEMP);
    localparam logic [TEMP_W-1:0]  HYST_T    = TEMP_W'(HYST);
    localparam logic [TIMER_W-1:0] HEAT_LAST = TIMER_W'(HEAT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [1:0] F_NONE    = 2'd0;
    localparam logic [1:0] F_DRY     = 2'd1;
    localparam logic [1:0] F_TIMEOUT = 2'd2;
    localparam logic [1:0] F_OVER    = 2'd3;

    state_t              state_q, state_d;
    logic                start_q;
    logic                keep_q, keep_d;
    logic [TEMP_W-1:0]   target_q, target_d;
    logic [TIMER_W-1:0]  heat_timer_q, heat_timer_d;
    logic [TIMER_W-1:0]  hold_timer_q, hold_timer_d;
    logic                hold_heat_q, hold_heat_d;
    logic [1:0]          fault_q, fault_d;

    logic                press, over_temp, dry, at_target, below_lower;
    logic [TEMP_W-1:0]   lower, warm_target;

    assign press       = start_button & ~start_q;
    assign over_temp   = temperature_sensor >= MAX_T;
    assign dry         = ~water_level_sensor;
    assign at_target   = temperature_sensor >= target_q;
    assign lower       = (target_q > HYST_T) ? target_q - HYST_T : '0;
    assign below_lower = temperature_sensor < lower;
    assign warm_target = (warm_setpoint > BOIL_T) ? BOIL_T : warm_setpoint;

    // Each branch below follows the fixed priority: over-temp, dry, timeout, cancel, normal progress.
    always_comb begin
        state_d      = state_q;
        keep_d       = keep_q;
        target_d     = target_q;
        heat_timer_d = heat_timer_q;
        hold_timer_d = hold_timer_q;
        hold_heat_d  = hold_heat_q;
        fault_d      = fault_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (over_temp) begin
                    state_d = S_FAULT;
                    fault_d = F_OVER;
                end else if (press && water_level_sensor) begin
                    state_d      = S_HEAT;
                    heat_timer_d = '0;
                    keep_d       = keep_warm;
                    target_d     = keep_warm ? warm_target : BOIL_T;
                end else if (state_q == S_DONE && dry) begin
                    state_d = S_IDLE;
                end
            end
            S_HEAT: begin
                if (over_temp) begin
                    state_d = S_FAULT;
                    fault_d = F_OVER;
                end else if (dry) begin
                    state_d = S_FAULT;
                    fault_d = F_DRY;
                end else if (heat_timer_q == HEAT_LAST && !at_target) begin
                    state_d = S_FAULT;
                    fault_d = F_TIMEOUT;
                end else if (press) begin
                    state_d = S_IDLE;
                end else if (at_target) begin
                    if (keep_q) begin
                        state_d      = S_HOLD;
                        hold_timer_d = '0;
                        hold_heat_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (heat_timer_q != '1) begin
                    heat_timer_d = heat_timer_q + TIMER_ONE;
                end
            end
            S_HOLD: begin
                if (over_temp) begin
                    state_d = S_FAULT;
                    fault_d = F_OVER;
                end else if (dry) begin
                    state_d = S_FAULT;
                    fault_d = F_DRY;
                end else if (press || hold_timer_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    if (hold_timer_q != '1) begin
                        hold_timer_d = hold_timer_q + TIMER_ONE;
                    end
                    if (at_target) begin
                        hold_heat_d = 1'b0;
                    end else if (below_lower) begin
                        hold_heat_d = 1'b1;
                    end
                end
            end
            S_FAULT: begin
                if (press && water_level_sensor && temperature_sensor < BOIL_T) begin
                    state_d = S_IDLE;
                    fault_d = F_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b1;
            keep_q       <= 1'b0;
            target_q     <= BOIL_T;
            heat_timer_q <= '0;
            hold_timer_q <= '0;
            hold_heat_q  <= 1'b0;
            fault_q      <= F_NONE;
        end else begin
            state_q      <= state_d;
            start_q      <= start_button;
            keep_q       <= keep_d;
            target_q     <= target_d;
            heat_timer_q <= heat_timer_d;
            hold_timer_q <= hold_timer_d;
            hold_heat_q  <= hold_heat_d;
            fault_q      <= fault_d;
        end
    end

    assign heater     = (state_q == S_HEAT) | ((state_q == S_HOLD) & hold_heat_q);
    assign indicator  = (state_q == S_DONE) | (state_q == S_HOLD);
    assign shutdown   = (state_q == S_FAULT);
    assign fault_code = fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_kettle_controller.sv
// tb/tb_kettle_controller.sv - directed and randomized check of kettle_controller against a behavioural model
module tb_kettle_controller;

    localparam int TW    = 8;
    localparam int BOIL  = 100;
    localparam int MAXT  = 120;
    localparam int HY    = 4;
    localparam int HTO   = 20;
    localparam int HOLDC = 10;

    logic          clk = 1'b0;
    logic          rst, btn, keep, water;
    logic [TW-1:0] setp, temp;
    logic          heater, indicator, shutdown;
    logic [1:0]    fault_code;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;
    int heat_cnt = 0;

    kettle_controller #(
        .TEMP_W(TW), .BOIL_TEMP(BOIL), .MAX_TEMP(MAXT), .HYST(HY),
        .HEAT_TIMEOUT(HTO), .HOLD_CYCLES(HOLDC), .TIMER_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start_button(btn), .keep_warm(keep),
        .warm_setpoint(setp), .temperature_sensor(temp), .water_level_sensor(water),
        .heater(heater), .indicator(indicator), .shutdown(shutdown),
        .fault_code(fault_code), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode names match the visible state numbering.
    localparam int IDLE = 0, HEAT = 1, HOLD = 2, DONE = 3, FAULT = 4;
    int m_state = IDLE;
    int m_target = BOIL;
    int m_code = 0;
    int m_in_heat = 0;
    int m_in_hold = 0;
    bit m_prev = 1'b1;
    bit m_keep = 1'b0;
    bit m_warming = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic trip(input int code);
        m_state = FAULT;
        m_code  = code;
    endtask

    task automatic begin_heat();
        m_state   = HEAT;
        m_in_heat = 0;
        m_keep    = keep;
        m_target  = keep ? ((int'(setp) < BOIL) ? int'(setp) : BOIL) : BOIL;
    endtask

    task automatic model_edge();
        bit pr;
        int t;
        int low;
        pr     = btn && !m_prev;
        m_prev = btn;
        t      = int'(temp);
        low    = (m_target > HY) ? m_target - HY : 0;
        if (rst) begin
            m_state = IDLE; m_prev = 1'b1; m_target = BOIL; m_keep = 1'b0;
            m_warming = 1'b0; m_code = 0; m_in_heat = 0; m_in_hold = 0;
        end else if (m_state == FAULT) begin
            if (pr && water && t < BOIL) begin
                m_state = IDLE;
                m_code  = 0;
            end
        end else if (t >= MAXT) begin
            trip(3);
        end else if (m_state == IDLE || m_state == DONE) begin
            if (pr && water) begin_heat();
            else if (m_state == DONE && !water) m_state = IDLE;
        end else if (m_state == HEAT) begin
            m_in_heat++;
            if (!water) trip(1);
            else if (t < m_target && m_in_heat == HTO) trip(2);
            else if (pr) m_state = IDLE;
            else if (t >= m_target) begin
                if (m_keep) begin
                    m_state = HOLD; m_in_hold = 0; m_warming = 1'b0;
                end else begin
                    m_state = DONE;
                end
            end
        end else begin
            m_in_hold++;
            if (!water) trip(1);
            else if (pr || m_in_hold == HOLDC) m_state = IDLE;
            else if (t >= m_target) m_warming = 1'b0;
            else if (t < low) m_warming = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("heater", 32'(heater), 32'(m_state == HEAT || (m_state == HOLD && m_warming)));
        chk("indicator", 32'(indicator), 32'(m_state == DONE || m_state == HOLD));
        chk("shutdown", 32'(shutdown), 32'(m_state == FAULT));
        chk("fault_code", 32'(fault_code), 32'(m_code));
        if (heater === 1'b1) heat_cnt++;
    endtask

    initial begin
        rst = 1'b1; btn = 1'b1; keep = 1'b0; water = 1'b1; setp = 8'd70; temp = 8'd20;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("held_button_idle", 32'(state), 32'd0);
        btn = 1'b0; step();
        btn = 1'b1; step();
        chk("press_heat", 32'(state), 32'd1);
        btn = 1'b0; step();
        btn = 1'b1; step();
        chk("cancel_idle", 32'(state), 32'd0);
        chk("cancel_heater", 32'(heater), 32'd0);
        btn = 1'b0; step();

        // Boil: temperature reaches 100 on the eighth edge in HEAT.
        heat_cnt = 0; btn = 1'b1; temp = 8'd20; step(); btn = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            temp = 8'(20 + 10 * k);
            step();
        end
        chk("boil_heat_cycles", 32'(heat_cnt), 32'd8);
        chk("boil_done", 32'(state), 32'd3);
        chk("boil_indicator", 32'(indicator), 32'd1);

        // Timeout from DONE re-boil with the temperature stuck.
        temp = 8'd50; heat_cnt = 0; btn = 1'b1; step(); btn = 1'b0;
        repeat (HTO) step();
        chk("timeout_heat_cycles", 32'(heat_cnt), 32'(HTO));
        chk("timeout_state", 32'(state), 32'd4);
        chk("timeout_code", 32'(fault_code), 32'd2);
        btn = 1'b1; step(); btn = 1'b0;
        chk("timeout_clear", 32'(fault_code), 32'd0);
        step();

        // Keep-warm with hysteresis.
        keep = 1'b1; setp = 8'd70; temp = 8'd60; btn = 1'b1; step(); btn = 1'b0;
        temp = 8'd70; step();
        chk("warm_hold", 32'(state), 32'd2);
        temp = 8'd65; step();
        chk("warm_reheat", 32'(heater), 32'd1);
        temp = 8'd70; step();
        chk("warm_off", 32'(heater), 32'd0);
        repeat (7) step();
        chk("warm_last_cycle", 32'(state), 32'd2);
        step();
        chk("warm_expire", 32'(state), 32'd0);
        chk("warm_indicator", 32'(indicator), 32'd0);

        // Over-temp beats dry; then dry alone.
        keep = 1'b0; temp = 8'd60; btn = 1'b1; step(); btn = 1'b0;
        water = 1'b0; temp = 8'd125; step();
        chk("prio_overtemp", 32'(fault_code), 32'd3);
        water = 1'b1; temp = 8'd50; btn = 1'b1; step(); btn = 1'b0; step();
        temp = 8'd60; btn = 1'b1; step(); btn = 1'b0;
        water = 1'b0; step();
        chk("dry_code", 32'(fault_code), 32'd1);
        water = 1'b1; temp = 8'd50; btn = 1'b1; step(); btn = 1'b0; step();

        // Setpoint clamp and latching.
        keep = 1'b1; setp = 8'd150; temp = 8'd90; btn = 1'b1; step(); btn = 1'b0;
        temp = 8'd99; step();
        chk("clamp_still_heat", 32'(state), 32'd1);
        temp = 8'd100; step();
        chk("clamp_hold", 32'(state), 32'd2);
        setp = 8'd10; temp = 8'd95; step();
        chk("clamp_latched", 32'(heater), 32'd1);
        repeat (10) step();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int t;
            rst   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) btn = ~btn;
            water = ($urandom_range(0, 59) != 0);
            keep  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) setp = 8'($urandom);
            case ($urandom_range(0, 19))
                0: temp = 8'($urandom);
                1: temp = 8'($urandom_range(95, 125));
                default: begin
                    t = int'(temp) + int'($urandom_range(0, 6)) - 3;
                    if (t < 0) t = 0;
                    if (t > 130) t = 130;
                    temp = 8'(t);
                end
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kettle_controller.md
# kettle_controller

Parametrised kettle control FSM. It generalises the single-mode ElectricKettle to configurable temperature width and thresholds, adds a keep-warm mode with hysteresis, a heat timeout, over-temperature and dry-boil protection, and a latched fault code. It sits between the front-panel button/sensor inputs and the heater driver and status LEDs.

## Interface
- TEMP_W, 8: temperature sensor width (unsigned, °C).
- BOIL_TEMP, 100: boil target; also the ceiling for the keep-warm setpoint.
- MAX_TEMP, 120: over-temperature trip level; MAX_TEMP > BOIL_TEMP.
- HYST, 4: keep-warm hysteresis band.
- HEAT_TIMEOUT, 1000: maximum cycles in HEAT; ≥1.
- HOLD_CYCLES, 5000: keep-warm duration in cycles; ≥1.
- TIMER_W, 16: timer width; 2^TIMER_W > max(HEAT_TIMEOUT, HOLD_CYCLES).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_button  in  1  start/cancel/clear; acts on rising edge only.
- keep_warm  in  1  mode select: 0 = boil, 1 = keep-warm. Latched at start.
- warm_setpoint  in  TEMP_W  keep-warm target. Latched at start.
- temperature_sensor  in  TEMP_W  water temperature.
- water_level_sensor  in  1  1 = water present.
- heater  out  1  heater enable.
- indicator  out  1  ready/warm lamp.
- shutdown  out  1  protective shutdown (FAULT state).
- fault_code  out  2  0 none, 1 dry, 2 timeout, 3 over-temp.
- state  out  3  0 IDLE, 1 HEAT, 2 HOLD, 3 DONE, 4 FAULT.

## Operation
- Start event: `press = start_button & ~start_q`. start_q registers start_button and resets to 1, so a button held through reset does not start the kettle.
- Target, latched on the press that enters HEAT: keep_warm ? min(warm_setpoint, BOIL_TEMP) : BOIL_TEMP. Later input changes are ignored until the next start.
- Lower threshold: target > HYST ? target − HYST : 0.
- IDLE: press with water_level_sensor=1 → HEAT (heat timer cleared). Press with water=0 is ignored.
- HEAT: heater=1. Heat timer increments each cycle.
  - temp ≥ target in boil mode → DONE.
  - temp ≥ target in keep-warm mode → HOLD with hold_heat=0 (hold timer cleared).
  - If the timer equals HEAT_TIMEOUT−1 and the target is not reached → FAULT, code 2.
- HOLD: heater = hold_heat.
  - hold_heat clears when temp ≥ target.
  - hold_heat sets when temp < lower threshold.
  - Hold timer equals HOLD_CYCLES−1 → IDLE.
- DONE: heater=0. Press with water=1 → HEAT (re-boil). water=0 → IDLE (no fault).
- Cancel: press in HEAT or HOLD → IDLE.
- Dry fault: water=0 in HEAT or HOLD → FAULT, code 1.
- Over-temp: temp ≥ MAX_TEMP in any non-FAULT state → FAULT, code 3.
- FAULT: heater=0, shutdown=1, fault_code held. Press with water=1 and temp < BOIL_TEMP → IDLE, fault_code cleared. Otherwise FAULT persists.
- Priority when events coincide at the same edge: over-temp > dry > timeout > cancel press > target reached/hold expiry.
- Outputs are a Moore decode of the state, hold_heat and fault registers. There is no combinational path from inputs to outputs.
  - indicator = (state==DONE) | (state==HOLD).
  - shutdown = (state==FAULT).
- Arithmetic: all comparisons are unsigned at TEMP_W. The threshold subtraction saturates at 0. Timers saturate and never wrap.

## Timing
- Reset (rst=1 at an edge) gives: state=IDLE, heater=0, indicator=0, shutdown=0, fault_code=0, timers=0, hold_heat=0, start_q=1, latched target=BOIL_TEMP. Reset takes priority over every event, including mid-HEAT and in FAULT.
- Latency: an input condition sampled at edge N produces the new state and outputs immediately after edge N, i.e. a one-edge response.
- Timeout: with no target reached, FAULT is entered at the HEAT_TIMEOUT-th edge after entering HEAT. heater is therefore 1 for exactly HEAT_TIMEOUT cycles.
- HOLD lasts exactly HOLD_CYCLES cycles unless pre-empted by a fault or cancel.
- A held button produces one press. A re-press requires start_button low for at least one sampled edge.

## Test plan
- Params TEMP_W=8, HEAT_TIMEOUT=20, HOLD_CYCLES=10, HYST=4. Boil: press, water=1, temp ramps 20→100 at cycle 8 → heater=1 for 8 cycles, then state=3, indicator=1, heater=0.
- Keep-warm: setpoint=70. Temp reaches 70 → HOLD, heater=0. Temp drops to 65 → heater=1. Temp rises to 70 → heater=0. After 10 cycles in HOLD → IDLE, indicator=0.
- Timeout: press, temp fixed at 50 → heater=1 for 20 cycles, then state=4, shutdown=1, fault_code=2. Press with temp=50 → IDLE, fault_code=0.
- Dry and priority: in HEAT, set water=0 and temp=125 on the same edge → FAULT with fault_code=3. Repeat with temp=60 → fault_code=1.
- Held button and cancel: hold start_button high across reset release → stays IDLE. Release, press → HEAT. Press again → IDLE, heater=0 after that edge.
- Setpoint clamp: setpoint=150 in keep-warm mode → HOLD entered at temp=100, not 150. A setpoint change during HOLD has no effect.
